// File: rtl/rr_burst_scheduler_pkg.sv
// Shared definitions for the round-robin burst scheduler: sizes, one-hot FSM
// encoding and a small one-hot helper.
package rr_burst_scheduler_pkg;

    localparam int NSRC   = 4;
    localparam int DEST_W = 2;

    typedef enum logic [4:0] {
        ST_ARB   = 5'b00001,
        ST_POP   = 5'b00010,
        ST_CAP   = 5'b00100,
        ST_PUSH  = 5'b01000,
        ST_STALL = 5'b10000
    } state_e;

    function automatic logic [NSRC-1:0] onehot(input logic [DEST_W-1:0] idx);
        logic [NSRC-1:0] base;
        base = {{(NSRC-1){1'b0}}, 1'b1};
        return base << idx;
    endfunction

endpackage

// File: rtl/rr_burst_scheduler_if.sv
// FIFO-side bundle of the scheduler. The master modport is the scheduler and
// the slave modport is the surrounding FIFO/control logic.
interface rr_burst_scheduler_if
    import rr_burst_scheduler_pkg::*;
#(
    parameter int DW = 10
) ();

    // Handshake: pop_out[i] is a one-cycle strobe that consumes one word from
    // input FIFO i, whose data shows up on data_in one cycle later. push_out[d]
    // is a one-cycle strobe that writes data_out into output d and is only
    // raised while afull_in[d] is low; afull is the only back-pressure.
    logic                 enable;
    logic [NSRC-1:0]      empty_in;
    logic [NSRC-1:0]      afull_in;
    logic [NSRC*DW-1:0]   data_in;
    logic [NSRC-1:0]      pop_out;
    logic [NSRC-1:0]      push_out;
    logic [DW-1:0]        data_out;
    logic [DEST_W-1:0]    sel_out;
    logic                 idle_out;
    state_e               state_dbg;

    modport master (
        input  enable, empty_in, afull_in, data_in,
        output pop_out, push_out, data_out, sel_out, idle_out, state_dbg
    );

    modport slave (
        output enable, empty_in, afull_in, data_in,
        input  pop_out, push_out, data_out, sel_out, idle_out, state_dbg
    );

endinterface

// File: rtl/rr_burst_scheduler_pick.sv
// Rotating priority encoder: picks the first requester at or above ptr_i,
// wrapping modulo four.
module rr_burst_scheduler_pick
    import rr_burst_scheduler_pkg::*;
(
    input  logic [NSRC-1:0]   req_i,
    input  logic [DEST_W-1:0] ptr_i,
    output logic [DEST_W-1:0] gnt_o,
    output logic              any_o
);

    logic [DEST_W-1:0] idx;

    // Walk from the farthest offset down so the closest requester wins last.
    always_comb begin
        gnt_o = ptr_i;
        idx   = ptr_i;
        for (int i = NSRC - 1; i >= 0; i--) begin
            idx = ptr_i + DEST_W'(i);
            if (req_i[idx]) begin
                gnt_o = idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler moving words from four input FIFOs to four
// output FIFOs selected by the top two bits of each word.
module rr_burst_scheduler
    import rr_burst_scheduler_pkg::*;
#(
    parameter int DW    = 10,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    rr_burst_scheduler_if.master  bus
);

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_e            state_q, state_d;
    logic [DEST_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]        burst_q, burst_d;
    logic [DEST_W-1:0] sel_q, sel_d;
    logic [DW-1:0]     hold_q, hold_d;
    logic [NSRC-1:0]   pop_q, pop_d;
    logic [NSRC-1:0]   push_q, push_d;
    logic [DW-1:0]     dout_q, dout_d;
    logic              idle_q, idle_d;

    logic [NSRC-1:0]   req;
    logic [DEST_W-1:0] gnt;
    logic              any;
    logic [DW-1:0]     heads [NSRC];
    logic [DW-1:0]     head;
    logic [DEST_W-1:0] head_dest;
    logic [DEST_W-1:0] hold_dest;
    logic              burst_more;

    for (genvar i = 0; i < NSRC; i++) begin : g_head
        assign heads[i] = bus.data_in[i*DW +: DW];
    end

    assign req        = bus.enable ? ~bus.empty_in : '0;
    assign head       = heads[sel_q];
    assign head_dest  = head[DW-1 -: DEST_W];
    assign hold_dest  = hold_q[DW-1 -: DEST_W];
    assign burst_more = bus.enable && !bus.empty_in[sel_q] && (burst_q < BURST_L);

    rr_burst_scheduler_pick u_rr_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .any_o (any)
    );

    // Outputs are computed one state ahead so every port is a flop.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        sel_d    = sel_q;
        hold_d   = hold_q;
        pop_d    = '0;
        push_d   = '0;
        dout_d   = dout_q;
        idle_d   = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                if (any) begin
                    sel_d   = gnt;
                    pop_d   = onehot(gnt);
                    state_d = ST_POP;
                end else begin
                    idle_d  = 1'b1;
                end
            end
            ST_POP: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                hold_d = head;
                if (!bus.afull_in[head_dest]) begin
                    push_d  = onehot(head_dest);
                    dout_d  = head;
                    burst_d = burst_q + 4'd1;
                    state_d = ST_PUSH;
                end else begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!bus.afull_in[hold_dest]) begin
                    push_d  = onehot(hold_dest);
                    dout_d  = hold_q;
                    burst_d = burst_q + 4'd1;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (burst_more) begin
                    pop_d   = onehot(sel_q);
                    state_d = ST_POP;
                end else begin
                    rr_ptr_d = sel_q + 2'd1;
                    burst_d  = '0;
                    idle_d   = 1'b1;
                    state_d  = ST_ARB;
                end
            end
            default: begin
                idle_d  = 1'b1;
                state_d = ST_ARB;
            end
        endcase
    end

    // An asynchronous reset discards any word sitting in the hold register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            burst_q  <= '0;
            sel_q    <= '0;
            hold_q   <= '0;
            pop_q    <= '0;
            push_q   <= '0;
            dout_q   <= '0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            dout_q   <= dout_d;
            idle_q   <= idle_d;
        end
    end

    assign bus.pop_out   = pop_q;
    assign bus.push_out  = push_q;
    assign bus.data_out  = dout_q;
    assign bus.sel_out   = sel_q;
    assign bus.idle_out  = idle_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler: input FIFOs with one-cycle read latency,
// a round-robin transaction planner and a per-cycle scoreboard.
module tb_rr_burst_scheduler;
    import rr_burst_scheduler_pkg::*;

    localparam int DW    = 10;
    localparam int BURST = 4;
    localparam int DEPTH = 16;
    localparam int LOGN  = 64;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;

    rr_burst_scheduler_if #(.DW(DW)) bus ();

    rr_burst_scheduler #(.DW(DW), .BURST(BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Source FIFO model: registered read data, updated one step after the edge.
    logic [DW-1:0] mem [4][DEPTH];
    int            wr_ptr [4];
    int            rd_ptr [4];
    logic [DW-1:0] rd_data [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.empty_in[i]          = (rd_ptr[i] == wr_ptr[i]);
            bus.data_in[i*DW +: DW]  = rd_data[i];
        end
    end

    always @(posedge clk) begin : fifo_model
        logic [3:0] p;
        p = bus.pop_out;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && rd_ptr[i] != wr_ptr[i]) begin
                rd_data[i] = mem[i][rd_ptr[i]];
                rd_ptr[i]  = rd_ptr[i] + 1;
            end
        end
    end

    // Scoreboard entries are {source, word}; destination is word[9:8].
    logic [11:0]   exp_q[$];
    int            pop_cnt, push_cnt;
    int            last_pop_cyc, last_push_cyc;
    logic [3:0]    last_pop_vec, last_push_vec;
    logic [DW-1:0] last_push_data;
    int            pop_cyc_log [LOGN];
    logic [1:0]    push_src_log [LOGN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [11:0] e;
        logic [3:0]  pop;
        logic [3:0]  push;
        pop  = bus.pop_out;
        push = bus.push_out;
        if (reset === 1'b1) begin
            check("pop_push_exclusive", 32'((|pop) && (|push)), 0);
            check("pop_onehot0", 32'($onehot0(pop)), 1);
            check("push_onehot0", 32'($onehot0(push)), 1);
            if (|pop) begin
                if (pop_cnt < LOGN) pop_cyc_log[pop_cnt] = cyc;
                pop_cnt++;
                last_pop_cyc = cyc;
                last_pop_vec = pop;
                check("pop_from_nonempty", 32'(pop & bus.empty_in), 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got %b required none", pop);
                end else begin
                    e = exp_q[0];
                    check("pop_source", 32'(pop), 32'(4'b0001 << e[11:10]));
                end
            end
            if (|push) begin
                last_push_cyc  = cyc;
                last_push_vec  = push;
                last_push_data = bus.data_out;
                if (push_cnt < LOGN) push_src_log[push_cnt] = bus.sel_out;
                push_cnt++;
                check("push_latency_ge2", 32'((cyc - last_pop_cyc) >= 2), 1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_push: got %b data %h required none", push, bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("push_dest", 32'(push), 32'(4'b0001 << e[9:8]));
                    check("push_data", 32'(bus.data_out), 32'(e[9:0]));
                    check("push_sel", 32'(bus.sel_out), 32'(e[11:10]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.enable    = 1'b0;
        bus.afull_in  = '0;
        for (int i = 0; i < 4; i++) begin
            wr_ptr[i]  = 0;
            rd_ptr[i]  = 0;
            rd_data[i] = '0;
        end
        exp_q.delete();
        pop_cnt      = 0;
        push_cnt     = 0;
        last_pop_cyc = 0;
        last_push_cyc = 0;
        last_pop_vec = '0;
        last_push_vec = '0;
        last_push_data = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic load(input int src, input logic [DW-1:0] word);
        mem[src][wr_ptr[src]] = word;
        wr_ptr[src] = wr_ptr[src] + 1;
    endtask

    // Expected order: from ptr, grant the first non-empty source, take up to BURST words, rotate.
    task automatic plan(input int start_ptr);
        int left [4];
        int pos [4];
        int ptr, g, n, total;
        logic [1:0] gs;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            pos[i]  = rd_ptr[i];
            left[i] = wr_ptr[i] - rd_ptr[i];
            total  += left[i];
        end
        ptr = start_ptr;
        while (total > 0) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && left[(ptr + k) % 4] > 0) g = (ptr + k) % 4;
            end
            n  = (left[g] < BURST) ? left[g] : BURST;
            gs = 2'(g);
            for (int k = 0; k < n; k++) begin
                exp_q.push_back({gs, mem[g][pos[g]]});
                pos[g]++;
                left[g]--;
                total--;
            end
            ptr = (g + 1) % 4;
        end
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        for (int i = 0; i < budget && pop_cnt < n; i++) begin
            @(negedge clk);
            #1;
        end
        check(name, 32'(pop_cnt >= n), 1);
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] w;
        int push_before;
        n_tests = 0;
        n_fail  = 0;

        // 1: single word from FIFO2, plus reset values.
        do_reset();
        @(negedge clk);
        check("rst_pop", 32'(bus.pop_out), 0);
        check("rst_push", 32'(bus.push_out), 0);
        check("rst_data", 32'(bus.data_out), 0);
        check("rst_sel", 32'(bus.sel_out), 0);
        check("rst_idle", 32'(bus.idle_out), 1);
        check("rst_state", 32'(bus.state_dbg), 32'(ST_ARB));
        tick(1);
        load(2, 10'h3A5);
        plan(0);
        bus.enable = 1'b1;
        drain(40, "t1_drain");
        check("t1_pop_vec", 32'(last_pop_vec), 32'h4);
        check("t1_push_vec", 32'(last_push_vec), 32'h8);
        check("t1_push_data", 32'(last_push_data), 32'h3A5);
        check("t1_latency", 32'(last_push_cyc - last_pop_cyc), 2);
        tick(3);
        check("t1_idle", 32'(bus.idle_out), 1);

        // 2: all four sources with 8 words each.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                w = {2'(k + s), 4'(s), 4'(k)};
                load(s, w);
            end
        end
        plan(0);
        bus.enable = 1'b1;
        drain(800, "t2_drain");
        check("t2_push_count", 32'(push_cnt), 32);
        for (int i = 0; i < 32; i++) begin
            check("t2_grant_order", 32'(push_src_log[i]), 32'((i / 4) % 4));
        end
        check("t2_pop_gap_in_burst", 32'(pop_cyc_log[1] - pop_cyc_log[0]), 3);
        check("t2_pop_gap_new_grant", 32'(pop_cyc_log[4] - pop_cyc_log[3]), 4);

        // 3: destination 1 almost-full for 10 cycles; output 3 almost-full throughout.
        do_reset();
        bus.afull_in = 4'b1010;
        load(0, 10'h1C3);
        plan(0);
        bus.enable = 1'b1;
        wait_pops(1, 20, "t3_wait_pop");
        tick(10);
        check("t3_stall_no_push", 32'(push_cnt), 0);
        bus.afull_in = 4'b1000;
        @(negedge clk);
        check("t3_no_push_same_cycle", 32'(bus.push_out), 0);
        @(negedge clk);
        check("t3_push_vec", 32'(bus.push_out), 32'h2);
        check("t3_push_data", 32'(bus.data_out), 32'h1C3);
        drain(10, "t3_drain");

        // 4: FIFO1 empties mid-burst, pointer moves on to 2 then 3.
        do_reset();
        load(1, 10'h005);
        load(1, 10'h106);
        load(2, 10'h207);
        load(3, 10'h308);
        plan(0);
        bus.enable = 1'b1;
        drain(100, "t4_drain");
        check("t4_push_count", 32'(push_cnt), 4);
        check("t4_src0", 32'(push_src_log[0]), 1);
        check("t4_src1", 32'(push_src_log[1]), 1);
        check("t4_src2", 32'(push_src_log[2]), 2);
        check("t4_src3", 32'(push_src_log[3]), 3);

        // 5: enable dropped during CAP.
        do_reset();
        load(0, 10'h011);
        load(0, 10'h112);
        load(0, 10'h213);
        exp_q.push_back({2'd0, 10'h011});
        bus.enable = 1'b1;
        wait_pops(1, 20, "t5_wait_pop");
        tick(1);
        bus.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_push_vec", 32'(bus.push_out), 32'h1);
        check("t5_push_data", 32'(bus.data_out), 32'h011);
        @(negedge clk);
        check("t5_idle", 32'(bus.idle_out), 1);
        tick(20);
        check("t5_pop_count", 32'(pop_cnt), 1);
        check("t5_push_count", 32'(push_cnt), 1);
        drain(1, "t5_drain");

        // 6: asynchronous reset while stalled.
        do_reset();
        bus.afull_in = 4'b0100;
        load(1, 10'h0AB);
        load(2, 10'h2F0);
        plan(0);
        bus.enable = 1'b1;
        wait_pops(2, 60, "t6_wait_pop");
        tick(4);
        @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_pop", 32'(bus.pop_out), 0);
        check("t6_rst_push", 32'(bus.push_out), 0);
        check("t6_rst_data", 32'(bus.data_out), 0);
        check("t6_rst_sel", 32'(bus.sel_out), 0);
        check("t6_rst_idle", 32'(bus.idle_out), 1);
        check("t6_rst_state", 32'(bus.state_dbg), 32'(ST_ARB));
        push_before = push_cnt;
        @(posedge clk);
        #2;
        reset = 1'b1;
        bus.afull_in = '0;
        tick(20);
        check("t6_pushes_before_reset", 32'(push_before), 1);
        check("t6_no_stale_push", 32'(push_cnt), 1);
        check("t6_pop_count", 32'(pop_cnt), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
